// File: rtl/keypad_1.sv
// keypad_1: 4x4 keypad column scanner with a four-key passcode lock
module keypad_1 #(
  parameter int SCAN_DWELL = 4,
  parameter logic [15:0] PASSCODE = 16'h1865
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       access_granted,
  output logic       led
);
  localparam logic [63:0] KEYMAP = 64'h123A_456B_789C_E0FD;
  localparam int DW = (SCAN_DWELL > 2) ? $clog2(SCAN_DWELL) : 1;
  typedef enum logic {SCAN, HELD} state_t;
  state_t state, state_nx;
  logic [3:0] col_r, key, idx;
  logic [1:0] ri, ci;
  logic [DW-1:0] dwell;
  logic [15:0] buffer;
  logic [2:0] count;
  logic chk, capture, advance;
  always_comb begin
    ri = row[3] ? 2'd0 : row[2] ? 2'd1 : row[1] ? 2'd2 : 2'd3;
    ci = col_r[3] ? 2'd0 : col_r[2] ? 2'd1 : col_r[1] ? 2'd2 : 2'd3;
    idx = ~{ri, ci};
    key = KEYMAP[{idx, 2'b00} +: 4];
    capture = en && state == SCAN && row != 4'h0;
    advance = en && state == SCAN && row == 4'h0 && dwell == DW'(SCAN_DWELL - 1);
    state_nx = !en ? SCAN : capture ? HELD : (state == HELD && row == 4'h0) ? SCAN : state;
    col = en ? col_r : 4'h0;
    led = en && state == HELD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      col_r <= 4'b1000;
      dwell <= '0;
      buffer <= '0;
      count <= '0;
      chk <= 1'b0;
      access_granted <= 1'b0;
    end else begin
      state <= state_nx;
      if (en) begin
        dwell <= (state == SCAN && row == 4'h0 && !advance) ? dwell + 1'b1 :
                 (state == HELD && row != 4'h0) ? dwell : '0;
        if (advance) col_r <= {col_r[0], col_r[3:1]};
        // grant is judged the cycle after the fourth key lands in the buffer
        if (chk) begin
          access_granted <= buffer == PASSCODE;
          chk <= 1'b0;
        end
        if (capture) begin
          if (key == 4'hE) begin
            buffer <= '0;
            count <= '0;
            chk <= 1'b0;
            access_granted <= 1'b0;
          end else if (count == 3'd4) begin
            buffer <= {12'h000, key};
            count <= 3'd1;
            access_granted <= 1'b0;
          end else begin
            buffer <= {buffer[11:0], key};
            count <= count + 3'd1;
            chk <= count == 3'd3;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_1.sv
// tb_keypad_1: directed and randomized checks of keypad_1 against a queue-based reference model
module tb_keypad_1;
  localparam int DWELL = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [3:0] row = 4'h0;
  logic [3:0] col;
  logic access_granted, led;
  int compared = 0, mismatched = 0;
  int keymap[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  int pass[4] = '{1, 8, 6, 5};
  int m_col = 0, m_dwell = 0;
  int q[$];
  bit m_held = 0, m_grant = 0, m_chk = 0;

  keypad_1 #(.SCAN_DWELL(DWELL), .PASSCODE(16'h1865)) dut (
    .clk(clk), .rst(rst), .en(en), .row(row),
    .col(col), .access_granted(access_granted), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int r, k;
    if (rst) begin
      m_col = 0; m_dwell = 0; m_held = 0; m_grant = 0; m_chk = 0;
      q.delete();
      return;
    end
    if (!en) begin
      m_held = 0;
      return;
    end
    if (m_chk) begin
      m_grant = 1;
      foreach (pass[i]) if (q[i] != pass[i]) m_grant = 0;
      m_chk = 0;
    end
    if (m_held) begin
      if (row == 4'h0) begin m_held = 0; m_dwell = 0; end
    end else if (row != 4'h0) begin
      r = 3;
      for (int i = 3; i >= 0; i--) if (row[i]) r = 3 - i;
      k = keymap[r][m_col];
      m_held = 1;
      m_dwell = 0;
      if (k == 14) begin
        q.delete(); m_grant = 0; m_chk = 0;
      end else begin
        if (q.size() == 4) begin q.delete(); m_grant = 0; end
        q.push_back(k);
        m_chk = q.size() == 4;
      end
    end else begin
      m_dwell++;
      if (m_dwell == DWELL) begin m_dwell = 0; m_col = (m_col + 1) % 4; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("col", col, en ? 4'(8 >> m_col) : 4'h0);
    check("led", {3'b0, led}, {3'b0, en && m_held});
    check("grant", {3'b0, access_granted}, {3'b0, m_grant});
  endtask

  task automatic press(int k, int hold, int rel);
    int r = 0, c = 0, n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (keymap[i][j] == k) begin r = i; c = j; end
    while (col !== 4'(8 >> c) && n < 4 * DWELL + 4) begin tick(); n++; end
    check("col_wait", col, 4'(8 >> c));
    row = 4'(8 >> r);
    repeat (hold) tick();
    row = 4'h0;
    repeat (rel) tick();
  endtask

  task automatic enter(int a, int b, int c, int d, int hold);
    press(a, hold, 2); press(b, hold, 2); press(c, hold, 2); press(d, hold, 1);
  endtask

  task automatic dir(string tag, bit exp);
    check(tag, {3'b0, access_granted}, {3'b0, exp});
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    dir("reset_grant", 0);
    check("reset_col", col, 4'b1000);
    rst = 1'b0;
    repeat (17) tick();
    enter(1, 8, 6, 5, 2);
    dir("grant_1865", 1);
    repeat (3) tick();
    dir("grant_holds", 1);
    enter(1, 8, 6, 4, 2);
    tick();
    dir("wrong_1864", 0);
    enter(1, 8, 6, 5, 2);
    dir("new_entry_1865", 1);
    press(1, 2, 2); press(8, 2, 2); press(14, 2, 2);
    enter(1, 8, 6, 5, 2);
    dir("after_clear", 1);
    press(2, 1, 1);
    dir("drop_on_key", 0);
    press(14, 2, 2);
    press(1, 20, 2);
    check("long_hold_col", col, 4'b1000);
    press(8, 2, 2); press(6, 2, 2); press(5, 2, 1);
    dir("long_hold_single", 1);
    press(14, 2, 2); press(1, 2, 2); press(8, 2, 2);
    en = 1'b0;
    row = 4'b1000;
    repeat (5) tick();
    check("disabled_col", col, 4'h0);
    row = 4'h0;
    tick();
    en = 1'b1;
    tick();
    press(6, 2, 2); press(5, 2, 1);
    dir("en_resume", 1);
    press(14, 1, 1);
    enter(1, 8, 6, 5, 1);
    dir("one_cycle", 1);
    press(1, 2, 2);
    row = 4'b0100;
    tick(); tick();
    rst = 1'b1;
    tick();
    dir("mid_reset", 0);
    rst = 1'b0;
    repeat (3) tick();
    row = 4'h0;
    tick();
    repeat (60) begin
      if ($urandom_range(0, 2) == 0) enter(1, 8, 6, 5, $urandom_range(1, 3));
      else enter($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(1, 3));
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (600) begin
      en = $urandom_range(0, 7) != 0;
      row = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 1'b0; en = 1'b1; row = 4'h0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
